// File: rtl/object_mask_tracker.sv
// Reduces a 1-bit object mask stream to one descriptor per frame: object pixel
// count, bounding box and a presence flag, delivered over a valid/ready port.
module object_mask_tracker #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic        object_image,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_count,
  output logic [7:0]  res_x_min,
  output logic [7:0]  res_x_max,
  output logic [7:0]  res_y_min,
  output logic [7:0]  res_y_max,
  output logic        res_present,
  output logic        res_overrun,
  output logic        frame_error,
  output logic        dbg_state
);

  localparam logic [7:0]  LAST_X  = 8'(WIDTH - 1);
  localparam logic [7:0]  LAST_Y  = 8'(HEIGHT - 1);
  localparam logic [16:0] MIN_CNT = 17'(MIN_PIXELS);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t      state;
  logic [7:0]  x_pos, y_pos;
  logic [15:0] acc_count;
  logic [7:0]  acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic        frame_done;

  logic        start, accept, hit, last_pix, transfer;
  logic [7:0]  cur_x, cur_y;
  logic [15:0] base_count, nxt_count;
  logic [7:0]  base_x_min, base_x_max, base_y_min, base_y_max;
  logic [7:0]  nxt_x_min, nxt_x_max, nxt_y_min, nxt_y_max;

  assign dbg_state = (state == SCAN);

  // A start-of-frame pixel restarts the position and accumulators in either
  // state, so its own contribution is folded in on top of the cleared values.
  always_comb begin
    start      = pix_valid && pix_sof;
    accept     = pix_valid && (pix_sof || state == SCAN);
    cur_x      = start ? 8'd0 : x_pos;
    cur_y      = start ? 8'd0 : y_pos;
    base_count = start ? 16'd0 : acc_count;
    base_x_min = start ? 8'hFF : acc_x_min;
    base_x_max = start ? 8'h00 : acc_x_max;
    base_y_min = start ? 8'hFF : acc_y_min;
    base_y_max = start ? 8'h00 : acc_y_max;
    hit        = accept && object_image;
    nxt_count  = base_count;
    nxt_x_min  = base_x_min;
    nxt_x_max  = base_x_max;
    nxt_y_min  = base_y_min;
    nxt_y_max  = base_y_max;
    if (hit) begin
      if (base_count != 16'hFFFF) nxt_count = base_count + 16'd1;
      if (cur_x < base_x_min) nxt_x_min = cur_x;
      if (cur_x > base_x_max) nxt_x_max = cur_x;
      if (cur_y < base_y_min) nxt_y_min = cur_y;
      if (cur_y > base_y_max) nxt_y_max = cur_y;
    end
    last_pix   = accept && (cur_x == LAST_X) && (cur_y == LAST_Y);
    transfer   = res_valid && res_ready;
  end

  // Result port: fields hold while res_valid && !res_ready; a transfer happens
  // on any edge where res_valid && res_ready; a new load may replace an
  // untransferred result, which is then flagged with res_overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      x_pos       <= '0;
      y_pos       <= '0;
      acc_count   <= '0;
      acc_x_min   <= '0;
      acc_x_max   <= '0;
      acc_y_min   <= '0;
      acc_y_max   <= '0;
      frame_done  <= 1'b0;
      res_valid   <= 1'b0;
      res_count   <= '0;
      res_x_min   <= '0;
      res_x_max   <= '0;
      res_y_min   <= '0;
      res_y_max   <= '0;
      res_present <= 1'b0;
      res_overrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      frame_done  <= last_pix;
      if (accept) begin
        acc_count <= nxt_count;
        acc_x_min <= nxt_x_min;
        acc_x_max <= nxt_x_max;
        acc_y_min <= nxt_y_min;
        acc_y_max <= nxt_y_max;
        if (cur_x == LAST_X) begin
          x_pos <= 8'd0;
          y_pos <= cur_y + 8'd1;
        end else begin
          x_pos <= cur_x + 8'd1;
          y_pos <= cur_y;
        end
        if (start) begin
          state       <= SCAN;
          frame_error <= (state == SCAN);
        end
        if (last_pix) state <= IDLE;
      end
      // Accumulators still hold the finished frame here even if a new frame
      // started on this same edge.
      if (frame_done) begin
        res_valid   <= 1'b1;
        res_count   <= acc_count;
        res_present <= ({1'b0, acc_count} >= MIN_CNT);
        res_overrun <= res_valid && !res_ready;
        if (acc_count == 16'd0) begin
          res_x_min <= '0;
          res_x_max <= '0;
          res_y_min <= '0;
          res_y_max <= '0;
        end else begin
          res_x_min <= acc_x_min;
          res_x_max <= acc_x_max;
          res_y_min <= acc_y_min;
          res_y_max <= acc_y_max;
        end
      end else if (transfer) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_object_mask_tracker.sv
// Directed bench for object_mask_tracker with a result scoreboard; a reduced
// frame size keeps the run short while still covering the planned pixel sites.
module tb_object_mask_tracker;

  localparam int W    = 48;
  localparam int H    = 96;
  localparam int MINP = 64;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0, pix_sof = 1'b0, object_image = 1'b0;
  logic        res_ready = 1'b1;
  logic        res_valid, res_present, res_overrun, frame_error, dbg_state;
  logic [15:0] res_count;
  logic [7:0]  res_x_min, res_x_max, res_y_min, res_y_max;

  int checks = 0;
  int errors = 0;
  logic [49:0] exp_q[$];
  int m_count, m_xmin, m_xmax, m_ymin, m_ymax;

  object_mask_tracker #(.WIDTH(W), .HEIGHT(H), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .object_image(object_image), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_x_min(res_x_min), .res_x_max(res_x_max),
    .res_y_min(res_y_min), .res_y_max(res_y_max), .res_present(res_present),
    .res_overrun(res_overrun), .frame_error(frame_error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [49:0] observed();
    return {res_count, res_x_min, res_x_max, res_y_min, res_y_max, res_present, res_overrun};
  endfunction

  function automatic logic [49:0] pack(int cnt, int xmin, int xmax, int ymin, int ymax, logic ov);
    logic pres;
    pres = (cnt >= MINP);
    if (cnt == 0) return {16'd0, 32'd0, 1'b0, ov};
    return {16'(cnt), 8'(xmin), 8'(xmax), 8'(ymin), 8'(ymax), pres, ov};
  endfunction

  function automatic logic obj_at(int m, int x, int y);
    case (m)
      0:       return 1'b0;
      1:       return (x == 37) && (y == 90);
      2:       return (x >= 10) && (x <= 17) && (y >= 20) && (y <= 27);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [49:0] obs, input logic [49:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare on every transfer
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", observed(), 50'h3_FFFF_FFFF_FFFF);
      end else begin
        check("result", observed(), exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      pix_valid    = 1'b0;
      pix_sof      = 1'($urandom_range(0, 1));
      object_image = 1'($urandom_range(0, 1));
      step();
    end
    pix_sof      = 1'b0;
    object_image = 1'b0;
  endtask

  task automatic send_pix(input logic sof, input logic obj);
    pix_valid    = 1'b1;
    pix_sof      = sof;
    object_image = obj;
    step();
    pix_valid    = 1'b0;
    pix_sof      = 1'b0;
    object_image = 1'b0;
  endtask

  task automatic send_range(input int m, input int first, input int last, input int gap_pct,
                            input bit abort);
    int x, y;
    logic obj;
    for (int i = first; i <= last; i++) begin
      x = i % W;
      y = i / W;
      obj = obj_at(m, x, y);
      if (i == 0) begin
        m_count = 0; m_xmin = 255; m_xmax = 0; m_ymin = 255; m_ymax = 0;
      end
      if (obj) begin
        m_count++;
        if (x < m_xmin) m_xmin = x;
        if (x > m_xmax) m_xmax = x;
        if (y < m_ymin) m_ymin = y;
        if (y > m_ymax) m_ymax = y;
      end
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      send_pix(i == 0, obj);
      if (i == 0) check("frame_error_at_sof", {49'd0, frame_error}, {49'd0, abort});
      if (i == 1 && abort) check("frame_error_clear", {49'd0, frame_error}, 50'd0);
    end
  endtask

  // push: 0 none, 1 expect overrun 0, 2 expect overrun 1
  task automatic send_frame(input int m, input int gap_pct, input bit abort, input int push);
    send_range(m, 0, NPIX - 1, gap_pct, abort);
    if (push != 0) exp_q.push_back(pack(m_count, m_xmin, m_xmax, m_ymin, m_ymax, push == 2));
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check("reset_fields", observed(), 50'd0);
    check("reset_flags", {47'd0, res_valid, frame_error, dbg_state}, 50'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // all-zero frame with latency checks
    send_frame(0, 0, 0, 1);
    check("latency_not_early", {49'd0, res_valid}, 50'd0);
    step();
    check("latency_valid", {49'd0, res_valid}, 50'd1);
    step();
    check("valid_drop", {49'd0, res_valid}, 50'd0);

    // single pixel, then 8x8 block at the presence threshold
    send_frame(1, 0, 0, 1);
    send_frame(2, 0, 0, 1);
    idle(3);

    // all ones with random input gaps
    send_frame(3, 20, 0, 1);
    idle(3);

    // early sof aborts a partial frame
    send_range(3, 0, 2999, 0, 0);
    send_frame(1, 0, 1, 1);
    idle(3);

    // held result then overwrite
    res_ready = 1'b0;
    send_frame(2, 0, 0, 0);
    step();
    check("hold_first", observed(), pack(64, 10, 17, 20, 27, 1'b0));
    idle(5);
    check("hold_stable", observed(), pack(64, 10, 17, 20, 27, 1'b0));
    check("hold_valid", {49'd0, res_valid}, 50'd1);
    send_frame(1, 0, 0, 2);
    step();
    check("overwrite", observed(), pack(1, 37, 37, 90, 90, 1'b1));
    res_ready = 1'b1;
    step();
    check("drop_after_ready", {49'd0, res_valid}, 50'd0);

    // asynchronous reset mid-frame with a result pending
    res_ready = 1'b0;
    send_frame(3, 0, 0, 0);
    step();
    check("pending_valid", {49'd0, res_valid}, 50'd1);
    send_range(3, 0, 999, 0, 0);
    #3 rst = 1'b0;
    #1;
    check("async_reset_fields", observed(), 50'd0);
    check("async_reset_flags", {47'd0, res_valid, frame_error, dbg_state}, 50'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    res_ready = 1'b1;
    repeat (20) send_pix(1'b0, 1'b1);
    check("stray_ignored", {48'd0, dbg_state, res_valid}, 50'd0);
    send_frame(2, 0, 0, 1);

    // drain scoreboard within a bounded budget
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    check("queue_drained", 50'(exp_q.size()), 50'd0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
